// File: rtl/host_bfm_tag_pool_if.sv
// Handshake/bus bundle for the host BFM tag pool: allocation, free, response, error and timeout signals.
interface host_bfm_tag_pool_if #(
    parameter int unsigned TAG_WIDTH  = 10,
    parameter int unsigned PFVF_WIDTH = 15
);
    logic                  alloc_req;
    logic [PFVF_WIDTH-1:0] alloc_pfvf;
    logic                  alloc_gnt;
    logic [TAG_WIDTH-1:0]  alloc_tag;
    logic                  free_valid;
    logic [TAG_WIDTH-1:0]  free_tag;
    logic                  free_rsp_valid;
    logic [TAG_WIDTH-1:0]  free_rsp_tag;
    logic [PFVF_WIDTH-1:0] free_rsp_pfvf;
    logic                  err_double_free;
    logic                  err_range;
    logic [TAG_WIDTH:0]    in_use_count;
    logic                  timeout_valid;
    logic [TAG_WIDTH-1:0]  timeout_tag;

    // Requester / completion-tracker side
    modport master (
        output alloc_req, alloc_pfvf, free_valid, free_tag,
        input  alloc_gnt, alloc_tag, free_rsp_valid, free_rsp_tag, free_rsp_pfvf,
               err_double_free, err_range, in_use_count, timeout_valid, timeout_tag
    );

    // Tag pool side
    modport slave (
        input  alloc_req, alloc_pfvf, free_valid, free_tag,
        output alloc_gnt, alloc_tag, free_rsp_valid, free_rsp_tag, free_rsp_pfvf,
               err_double_free, err_range, in_use_count, timeout_valid, timeout_tag
    );
endinterface

// File: rtl/host_bfm_tag_pool.sv
// PCIe packet-tag allocator: fresh pointer plus recycle FIFO, per-tag PF/VF context, free-error detection.
// Optional tag age-out scanner is enabled by defining HOST_BFM_TAG_TIMEOUT_EN.
module host_bfm_tag_pool #(
    parameter int unsigned TAG_WIDTH      = 10,
    parameter int unsigned NUM_TAGS       = 256,
    parameter int unsigned PFVF_WIDTH     = 15,
    parameter int unsigned TIMEOUT_CYCLES = 4096
) (
    input  logic                 clk,
    input  logic                 rst,
    host_bfm_tag_pool_if.slave   bus
);
    localparam int unsigned IDX_W = (NUM_TAGS > 2) ? $clog2(NUM_TAGS) : 1;
    localparam int unsigned CNT_W = TAG_WIDTH + 1;
    localparam logic [CNT_W-1:0] NUM_TAGS_C = CNT_W'(NUM_TAGS);
    localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(NUM_TAGS - 1);

    function automatic logic [IDX_W-1:0] next_ptr(input logic [IDX_W-1:0] p);
        return (p == LAST_IDX) ? '0 : p + IDX_W'(1);
    endfunction

    logic [NUM_TAGS-1:0]   in_use_q, in_use_d;
    logic [CNT_W-1:0]      fresh_q, fresh_d;
    logic [IDX_W-1:0]      rd_ptr_q, rd_ptr_d;
    logic [IDX_W-1:0]      wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0]      fifo_cnt_q, fifo_cnt_d;
    logic [CNT_W-1:0]      use_cnt_q, use_cnt_d;
    logic                  free_rsp_valid_q, free_rsp_valid_d;
    logic [TAG_WIDTH-1:0]  free_rsp_tag_q, free_rsp_tag_d;
    logic [PFVF_WIDTH-1:0] free_rsp_pfvf_q, free_rsp_pfvf_d;
    logic                  err_double_free_q, err_double_free_d;
    logic                  err_range_q, err_range_d;

    logic [TAG_WIDTH-1:0]  fifo_mem [NUM_TAGS];
    logic [PFVF_WIDTH-1:0] pfvf_mem [NUM_TAGS];

    logic                  fifo_empty;
    logic                  alloc_gnt_c;
    logic [TAG_WIDTH-1:0]  alloc_tag_c;
    logic                  alloc_fire;
    logic [IDX_W-1:0]      alloc_idx;
    logic                  free_in_range;
    logic [IDX_W-1:0]      free_idx;
    logic                  free_ok;
    logic                  auto_free;
    logic [IDX_W-1:0]      auto_idx;
    logic                  pop;
    logic [1:0]            n_push;
    logic                  wa_en, wb_en;
    logic [IDX_W-1:0]      wa_addr, wb_addr;
    logic [TAG_WIDTH-1:0]  wa_data, wb_data;
    logic                  fifo_room_ok;

    // Offer depends on registered state only; recycled tags take priority over fresh ones
    assign fifo_empty    = (fifo_cnt_q == '0);
    assign alloc_gnt_c   = !fifo_empty || (fresh_q != NUM_TAGS_C);
    assign alloc_tag_c   = fifo_empty ? TAG_WIDTH'(fresh_q) : fifo_mem[rd_ptr_q];
    assign alloc_fire    = bus.alloc_req && alloc_gnt_c;
    assign alloc_idx     = IDX_W'(alloc_tag_c);
    assign pop           = alloc_fire && !fifo_empty;

    assign free_in_range = ({1'b0, bus.free_tag} < NUM_TAGS_C);
    assign free_idx      = IDX_W'(bus.free_tag);
    assign free_ok       = bus.free_valid && free_in_range && in_use_q[free_idx];
    assign n_push        = {1'b0, free_ok} + {1'b0, auto_free};

    always_comb begin
        in_use_d          = in_use_q;
        fresh_d           = fresh_q;
        rd_ptr_d          = rd_ptr_q;
        wr_ptr_d          = wr_ptr_q;
        fifo_cnt_d        = fifo_cnt_q + CNT_W'(n_push) - CNT_W'(pop);
        use_cnt_d         = use_cnt_q + CNT_W'(alloc_fire) - CNT_W'(free_ok) - CNT_W'(auto_free);
        free_rsp_valid_d  = free_ok;
        free_rsp_tag_d    = free_rsp_tag_q;
        free_rsp_pfvf_d   = free_rsp_pfvf_q;
        err_range_d       = bus.free_valid && !free_in_range;
        err_double_free_d = bus.free_valid && free_in_range && !in_use_q[free_idx];
        wa_en             = 1'b0;
        wa_addr           = wr_ptr_q;
        wa_data           = bus.free_tag;
        wb_en             = 1'b0;
        wb_addr           = next_ptr(wr_ptr_q);
        wb_data           = TAG_WIDTH'(auto_idx);

        if (alloc_fire) begin
            in_use_d[alloc_idx] = 1'b1;
            if (fifo_empty) fresh_d  = fresh_q + CNT_W'(1);
            else            rd_ptr_d = next_ptr(rd_ptr_q);
        end
        if (free_ok) begin
            in_use_d[free_idx] = 1'b0;
            free_rsp_tag_d     = bus.free_tag;
            free_rsp_pfvf_d    = pfvf_mem[free_idx];
        end
        if (auto_free) in_use_d[auto_idx] = 1'b0;

        // User free occupies the first FIFO slot; an auto-free takes the next one
        if (free_ok) begin
            wa_en = 1'b1;
            wb_en = auto_free;
        end else if (auto_free) begin
            wa_en   = 1'b1;
            wa_data = TAG_WIDTH'(auto_idx);
        end
        case (n_push)
            2'd1:    wr_ptr_d = next_ptr(wr_ptr_q);
            2'd2:    wr_ptr_d = next_ptr(next_ptr(wr_ptr_q));
            default: wr_ptr_d = wr_ptr_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            in_use_q          <= '0;
            fresh_q           <= '0;
            rd_ptr_q          <= '0;
            wr_ptr_q          <= '0;
            fifo_cnt_q        <= '0;
            use_cnt_q         <= '0;
            free_rsp_valid_q  <= 1'b0;
            free_rsp_tag_q    <= '0;
            free_rsp_pfvf_q   <= '0;
            err_double_free_q <= 1'b0;
            err_range_q       <= 1'b0;
        end else begin
            in_use_q          <= in_use_d;
            fresh_q           <= fresh_d;
            rd_ptr_q          <= rd_ptr_d;
            wr_ptr_q          <= wr_ptr_d;
            fifo_cnt_q        <= fifo_cnt_d;
            use_cnt_q         <= use_cnt_d;
            free_rsp_valid_q  <= free_rsp_valid_d;
            free_rsp_tag_q    <= free_rsp_tag_d;
            free_rsp_pfvf_q   <= free_rsp_pfvf_d;
            err_double_free_q <= err_double_free_d;
            err_range_q       <= err_range_d;
        end
    end

    // Context and recycle storage need no reset: validity is tracked by in_use_q and fifo_cnt_q
    always_ff @(posedge clk) begin
        if (alloc_fire) pfvf_mem[alloc_idx] <= bus.alloc_pfvf;
        if (wa_en)      fifo_mem[wa_addr]   <= wa_data;
        if (wb_en)      fifo_mem[wb_addr]   <= wb_data;
    end

    assign fifo_room_ok = ((CNT_W+1)'(fifo_cnt_q) + (CNT_W+1)'(n_push))
                          <= ((CNT_W+1)'(NUM_TAGS) + (CNT_W+1)'(pop));
    assert property (@(posedge clk) disable iff (rst) fifo_room_ok);

`ifdef HOST_BFM_TAG_TIMEOUT_EN
    logic [31:0]          ts_q, ts_d;
    logic [IDX_W-1:0]     scan_q, scan_d;
    logic                 to_valid_q, to_valid_d;
    logic [TAG_WIDTH-1:0] to_tag_q, to_tag_d;
    logic [31:0]          stamp_mem [NUM_TAGS];
    logic [31:0]          age;

    // A user free of the scanned tag in the same cycle takes precedence over the age-out
    assign age       = ts_q - stamp_mem[scan_q];
    assign auto_free = in_use_q[scan_q] && (age > 32'(TIMEOUT_CYCLES))
                       && !(free_ok && (free_idx == scan_q));
    assign auto_idx  = scan_q;

    always_comb begin
        ts_d       = ts_q + 32'd1;
        scan_d     = next_ptr(scan_q);
        to_valid_d = auto_free;
        to_tag_d   = auto_free ? TAG_WIDTH'(scan_q) : '0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ts_q       <= '0;
            scan_q     <= '0;
            to_valid_q <= 1'b0;
            to_tag_q   <= '0;
        end else begin
            ts_q       <= ts_d;
            scan_q     <= scan_d;
            to_valid_q <= to_valid_d;
            to_tag_q   <= to_tag_d;
        end
    end

    always_ff @(posedge clk) begin
        if (alloc_fire) stamp_mem[alloc_idx] <= ts_q;
    end

    assign bus.timeout_valid = to_valid_q;
    assign bus.timeout_tag   = to_tag_q;
`else
    assign auto_free         = 1'b0;
    assign auto_idx          = '0;
    assign bus.timeout_valid = 1'b0;
    assign bus.timeout_tag   = '0;
`endif

    assign bus.alloc_gnt       = alloc_gnt_c;
    assign bus.alloc_tag       = alloc_tag_c;
    assign bus.free_rsp_valid  = free_rsp_valid_q;
    assign bus.free_rsp_tag    = free_rsp_tag_q;
    assign bus.free_rsp_pfvf   = free_rsp_pfvf_q;
    assign bus.err_double_free = err_double_free_q;
    assign bus.err_range       = err_range_q;
    assign bus.in_use_count    = use_cnt_q;
endmodule
